// File: rtl/cm_pkg.sv
// Shared CM reply codes and timer state encoding.
// Imported by the reply timer and by the guess-sequencing FSM.
package cm_pkg;

    // Reply bytes the target puts on the CM bus.
    localparam logic [7:0] CM_PASS = 8'hA5;
    localparam logic [7:0] CM_FAIL = 8'h5A;
    localparam logic [7:0] CM_SYNC = 8'hCC;

    // Reply timer state.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } tmr_state_e;

    // True when a bus byte is one of the two reply codes.
    function automatic logic is_reply(input logic [7:0] b,
                                      input logic [7:0] pass_code,
                                      input logic [7:0] fail_code);
        return (b == pass_code) || (b == fail_code);
    endfunction

endpackage

// File: rtl/cm_rx_filter.sv
// CM bus receive filter: a 2-flop synchroniser followed by a stability
// check. filt only follows the synchronised byte once it has been seen
// unchanged on two consecutive cycles, so single-cycle glitches and
// multi-bit skew while the bus settles never reach filt.
module cm_rx_filter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic [7:0] filt
);

    logic [7:0] s1_q, s2_q, s3_q, filt_q;
    logic [7:0] filt_d;

    // Accept the synchronised byte only when it matches last cycle's value.
    always_comb begin
        filt_d = filt_q;
        if (s2_q == s3_q) filt_d = s2_q;
    end

    // Synchroniser, compare register and filtered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            s3_q   <= 8'h00;
            filt_q <= 8'h00;
        end else begin
            s1_q   <= data_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/cm_reply_timer.sv
// CM reply latency timer.
// Starts on the rising edge of the FSM send strobe, counts clk cycles
// until a fresh PASS/FAIL byte shows up on the filtered bus (or until
// TIMEOUT) and reports the count together with the guess that caused it.
// The count includes the fixed 3-cycle latency of the receive filter.
// Optional feature macro: CM_REPLY_TIMER_BEST_EN builds the slowest-guess
// tracker; without it best_guess/best_cycles are tied to 0.
module cm_reply_timer
    import cm_pkg::*;
#(
    parameter int         CNT_W     = 16,
    parameter int         TIMEOUT   = 50000,
    parameter logic [7:0] PASS_CODE = CM_PASS,
    parameter logic [7:0] FAIL_CODE = CM_FAIL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       guess_in,
    input  logic [7:0]       data_in,
    output logic             busy,
    output logic             meas_valid,
    output logic [7:0]       meas_guess,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             meas_pass,
    output logic             meas_timeout,
    output logic [7:0]       best_guess,
    output logic [CNT_W-1:0] best_cycles
);

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tmr_state_e       state_q, state_d;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       guess_q, guess_d;
    logic             armed_q, armed_d;

    logic             mv_q, mv_d;
    logic [7:0]       mguess_q, mguess_d;
    logic [CNT_W-1:0] mcyc_q, mcyc_d;
    logic             mpass_q, mpass_d;
    logic             mto_q, mto_d;

    logic [7:0]       filt;
    logic             rise;
    logic             code_seen;
    logic             rpt;
    logic             rpt_pass;
    logic             rpt_to;

    cm_rx_filter u_filt (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .filt    (filt)
    );

    assign rise      = start & ~start_q;
    assign code_seen = is_reply(filt, PASS_CODE, FAIL_CODE);

    // Measurement FSM: a new send always restarts the count (dropping any
    // measurement in flight); otherwise a reply beats a timeout. armed only
    // rises after the bus has shown a non-reply byte, so a reply code left
    // over from the previous round cannot end the new measurement.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        guess_d  = guess_q;
        armed_d  = armed_q;
        rpt      = 1'b0;
        rpt_pass = 1'b0;
        rpt_to   = 1'b0;
        if (rise) begin
            guess_d = guess_in;
            cnt_d   = '0;
            armed_d = 1'b0;
            state_d = COUNT;
        end else if (state_q == COUNT) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (!code_seen) armed_d = 1'b1;
            if (armed_q && code_seen) begin
                rpt      = 1'b1;
                rpt_pass = (filt == PASS_CODE);
                state_d  = IDLE;
            end else if (cnt_q == TMO_CNT) begin
                rpt     = 1'b1;
                rpt_to  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // Report registers: pulse valid for one cycle, hold fields until the next report.
    always_comb begin
        mv_d     = rpt;
        mguess_d = mguess_q;
        mcyc_d   = mcyc_q;
        mpass_d  = mpass_q;
        mto_d    = mto_q;
        if (rpt) begin
            mguess_d = guess_q;
            mcyc_d   = cnt_q;
            mpass_d  = rpt_pass;
            mto_d    = rpt_to;
        end
    end

    // State, counter and report registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            guess_q  <= 8'h00;
            armed_q  <= 1'b0;
            mv_q     <= 1'b0;
            mguess_q <= 8'h00;
            mcyc_q   <= '0;
            mpass_q  <= 1'b0;
            mto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            cnt_q    <= cnt_d;
            guess_q  <= guess_d;
            armed_q  <= armed_d;
            mv_q     <= mv_d;
            mguess_q <= mguess_d;
            mcyc_q   <= mcyc_d;
            mpass_q  <= mpass_d;
            mto_q    <= mto_d;
        end
    end

    assign busy         = (state_q == COUNT);
    assign meas_valid   = mv_q;
    assign meas_guess   = mguess_q;
    assign meas_cycles  = mcyc_q;
    assign meas_pass    = mpass_q;
    assign meas_timeout = mto_q;

`ifdef CM_REPLY_TIMER_BEST_EN
    logic [7:0]       bguess_q, bguess_d;
    logic [CNT_W-1:0] bcyc_q, bcyc_d;

    // Slowest guess so far: strictly greater wins, so ties keep the earlier guess.
    always_comb begin
        bguess_d = bguess_q;
        bcyc_d   = bcyc_q;
        if (rpt && !rpt_to && (cnt_q > bcyc_q)) begin
            bguess_d = guess_q;
            bcyc_d   = cnt_q;
        end
    end

    // Tracker registers, updated on the same edge as the report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bguess_q <= 8'h00;
            bcyc_q   <= '0;
        end else begin
            bguess_q <= bguess_d;
            bcyc_q   <= bcyc_d;
        end
    end

    assign best_guess  = bguess_q;
    assign best_cycles = bcyc_q;
`else
    assign best_guess  = 8'h00;
    assign best_cycles = '0;
`endif

endmodule

// File: doc/cm_reply_timer.md
# cm_reply_timer

Measures per-guess response latency on the CM byte bus. Sits downstream of the CM bus interface and beside the guess-sequencing FSM, in the same clock domain as that FSM. It starts on the FSM's send strobe, counts clock cycles until the target's reply byte appears on the synchronised bus, and reports the count with the guess that produced it. It also tracks the slowest-responding guess, which is the timing-attack result.

## Interface
Parameters:
- CNT_W, 16, cycle counter width.
- TIMEOUT, 50000, cycle count that aborts a measurement; must be < 2^CNT_W.
- PASS_CODE, 8'hA5, reply byte meaning the guess was accepted.
- FAIL_CODE, 8'h5A, reply byte meaning the guess was rejected.

Ports:
- One clock; reset is asynchronous and active-high.
- clk  in  1  sole clock (FSM clock).
- rst  in  1  reset.
- start  in  1  send strobe from the FSM (high in its SEND state).
- guess_in  in  8  byte being sent, sampled on the start edge.
- data_in  in  8  bus byte from the CM interface; asynchronous to clk.
- busy  out  1  measurement in progress.
- meas_valid  out  1  one-cycle report pulse.
- meas_guess  out  8  guess of the reported measurement.
- meas_cycles  out  CNT_W  measured cycles.
- meas_pass  out  1  reply was PASS_CODE.
- meas_timeout  out  1  measurement ended by timeout.
- best_guess  out  8  guess with the largest non-timeout meas_cycles so far.
- best_cycles  out  CNT_W  that count.

## Operation
- Input filter (cm_rx_filter):
  - data_in passes through a 2-flop synchroniser (s1, s2), then a compare register s3.
  - filt takes the value of s2 only on a cycle where s2 == s3.
  - All filter registers reset to 8'h00.
- State machine: IDLE, COUNT.
- Start detect: start_q is start delayed one cycle; rise = start & ~start_q.
- On rise in any state:
  - latch guess_in into guess, cnt <= 0, armed <= 0, state <= COUNT.
  - A measurement already in progress is dropped with no meas_valid.
- In COUNT, each cycle without a rise:
  - cnt increments, saturating at 2^CNT_W-1.
  - armed <= 1 once filt is neither PASS_CODE nor FAIL_CODE. Stale reply bytes from the previous round are therefore ignored.
- Reply: in COUNT with armed=1 and filt equal to PASS_CODE or FAIL_CODE:
  - meas_cycles <= cnt, meas_guess <= guess, meas_pass <= (filt == PASS_CODE), meas_timeout <= 0, meas_valid <= 1, state <= IDLE.
- Timeout: in COUNT with cnt == TIMEOUT and no reply:
  - report as above with meas_pass=0, meas_timeout=1, state <= IDLE.
- Priority when events coincide: rise > reply > timeout.
- busy = (state == COUNT).
- Best tracker:
  - Updates on a non-timeout report when meas_cycles strictly exceeds best_cycles; best_cycles and best_guess take the report's values.
  - Ties keep the earlier guess.

## Timing
- Reset values: state=IDLE; start_q, armed, cnt, guess, filt = 0; all outputs = 0.
- Rise sampled at edge N: busy=1 and cnt=0 after edge N.
- Filter latency: a data_in change that stays stable appears on filt 3 edges later.
- meas_cycles includes this fixed 3-cycle offset; the block does not subtract it.
- meas_valid goes high on the edge after the detecting cycle and lasts exactly one cycle.
- meas_* fields hold their values until the next report.
- best_* updates on the same edge that meas_valid asserts.
- Reset asserted mid-measurement returns the block to its reset values immediately, with no report.

## Configuration
- CM_REPLY_TIMER_BEST_EN:
  - Defined: the best tracker is built as described above.
  - Undefined: no tracker registers are built, and best_guess and best_cycles are constant 0.
  - All other behaviour is identical in both builds.

## Structure
- Package cm_pkg holds:
  - the reply-code constants shared with the guess FSM (CM_PASS = 8'hA5, CM_FAIL = 8'h5A, CM_SYNC = 8'hCC);
  - the timer state enum (IDLE, COUNT).
- Sub-module cm_rx_filter (clk, rst, data_in, filt) contains the synchroniser and stability filter, so the guess FSM can reuse it.

## Test plan
- Guess 8'h07; data_in goes 8'h00 → 8'hA5 twenty cycles after the rise → one meas_valid with meas_guess=07, meas_pass=1, meas_cycles=23, meas_timeout=0.
- data_in held at 8'h5A from before the rise and through the round → no report until timeout; then meas_valid with meas_timeout=1, meas_cycles=TIMEOUT. Repeat with data_in going 8'h00 then 8'h5A → normal report, meas_pass=0.
- A second rise 10 cycles into a measurement → no report for the first measurement; the next report carries the second guess, with cnt counted from the second rise.
- data_in glitches to 8'hA5 for a single cycle → filt unchanged and no report.
- Rise coincident with a qualifying reply → no report; new measurement starts with cnt=0 and armed=0.
- Built with CM_REPLY_TIMER_BEST_EN, three reports with cycles 30 (guess 01), 45 (guess 02), 45 (guess 03) → best_guess=02, best_cycles=45; asserting rst mid-measurement clears everything to 0. Built without the macro → best_* stay 0.
